// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined RV32 data RAM: func3 codes, clear FSM
// encoding, response pipeline word and the access legality rule.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  // Unsigned widths exist only for loads; halfwords need bit 0 clear, words both.
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lane);
    logic ok;
    case (f3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~lane[0];
      F3_LW:   ok = (lane == 2'b00);
      F3_LBU:  ok = ~we;
      F3_LHU:  ok = ~we & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load extender: selects the byte/half at the given lane of a little-endian
// word and sign- or zero-extends it according to func3.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [31:0] sh_s;

  // Shift the addressed lane down to bit 0, then extend.
  always_comb begin
    sh_s = word_i >> {lane_i, 3'b000};
    case (func3_i)
      F3_LB:   data_o = {{24{sh_s[7]}}, sh_s[7:0]};
      F3_LH:   data_o = {{16{sh_s[15]}}, sh_s[15:0]};
      F3_LW:   data_o = word_i;
      F3_LBU:  data_o = {24'h000000, sh_s[7:0]};
      F3_LHU:  data_o = {16'h0000, sh_s[15:0]};
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_pipe_ram.sv
// Byte-addressed RV32 data RAM with valid/ready requests, a fixed-latency
// response shift pipeline and a word-per-cycle hardware clear engine.
module dmem_pipe_ram
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 9,
  parameter int    READ_LAT   = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_func3,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** IW;

  logic [31:0]   mem_q [WORDS];
  clr_state_e    clr_state_q, clr_state_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;
  logic          clr_done_q, clr_done_d;
  rsp_t          pipe_q [READ_LAT];
  rsp_t          stage_d;

  logic          accept_s;
  logic [IW-1:0] widx_s;
  logic [1:0]    lane_s;
  logic          legal_s;
  logic          wr_en_s;
  logic [3:0]    be_s;
  logic [31:0]   wdat_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   ext_s;

  assign clr_busy  = (clr_state_q == ST_CLEAR);
  assign clr_done  = clr_done_q;
  assign req_ready = ~clr_busy;

  assign accept_s  = req_valid & req_ready;
  assign widx_s    = req_addr[ADDR_WIDTH-1:2];
  assign lane_s    = req_addr[1:0];
  assign legal_s   = access_legal(req_we, req_func3, lane_s);
  assign wr_en_s   = accept_s & req_we & legal_s;
  assign rd_word_s = mem_q[widx_s];

  // Replicated store data lets the byte enables alone pick the lanes.
  always_comb begin
    be_s   = 4'b0000;
    wdat_s = 32'h0000_0000;
    case (req_func3)
      F3_SB: begin
        be_s   = 4'b0001 << lane_s;
        wdat_s = {4{req_wdata[7:0]}};
      end
      F3_SH: begin
        be_s   = lane_s[1] ? 4'b1100 : 4'b0011;
        wdat_s = {2{req_wdata[15:0]}};
      end
      F3_SW: begin
        be_s   = 4'b1111;
        wdat_s = req_wdata;
      end
      default: begin
        be_s   = 4'b0000;
        wdat_s = 32'h0000_0000;
      end
    endcase
  end

  dmem_load_ext u_ext (
    .word_i  (rd_word_s),
    .lane_i  (lane_s),
    .func3_i (req_func3),
    .data_o  (ext_s)
  );

  // Array write port: clear engine has priority, reset suppresses clearing.
  always_ff @(posedge clk) begin
    if (clr_state_q == ST_CLEAR && !rst) begin
      mem_q[clr_cnt_q] <= 32'h0000_0000;
    end else if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) mem_q[widx_s][8*b +: 8] <= wdat_s[8*b +: 8];
      end
    end
  end

  // Clear FSM next-state logic.
  always_comb begin
    clr_state_d = clr_state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_done_d  = 1'b0;
    case (clr_state_q)
      ST_IDLE: begin
        if (clr_start) begin
          clr_state_d = ST_CLEAR;
          clr_cnt_d   = '0;
        end else begin
          clr_state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == {IW{1'b1}}) begin
          clr_state_d = ST_IDLE;
          clr_done_d  = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + IW'(1);
        end
      end
      default: clr_state_d = ST_IDLE;
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_state_q <= ST_IDLE;
      clr_cnt_q   <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_done_q  <= clr_done_d;
    end
  end

  // Stores and errors answer with zero data.
  always_comb begin
    stage_d.valid = accept_s;
    stage_d.err   = accept_s & ~legal_s;
    if (accept_s && legal_s && !req_we) begin
      stage_d.data = ext_s;
    end else begin
      stage_d.data = 32'h0000_0000;
    end
  end

  // Response shift pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rsp_valid = pipe_q[READ_LAT-1].valid;
  assign rsp_data  = pipe_q[READ_LAT-1].data;
  assign rsp_err   = pipe_q[READ_LAT-1].err;

endmodule

// File: tb/tb_dmem_pipe_ram.sv
// Scoreboard bench: two instances (READ_LAT 1 and 3, ADDR_WIDTH 6) share the
// stimulus; expected responses are queued with their due cycle at issue time.
module tb_dmem_pipe_ram;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [5:0]  req_addr = 6'd0;
  logic [2:0]  req_func3 = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        clr_start = 1'b0;

  logic        rdy1, rv1, re1, busy1, done1;
  logic        rdy3, rv3, re3, busy3, done3;
  logic [31:0] rd1, rd3;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q1[$];
  exp_t q3[$];

  dmem_pipe_ram #(.ADDR_WIDTH(6), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_func3(req_func3),
    .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_data(rd1), .rsp_err(re1),
    .clr_start(clr_start), .clr_busy(busy1), .clr_done(done1)
  );

  dmem_pipe_ram #(.ADDR_WIDTH(6), .READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3),
    .req_we(req_we), .req_addr(req_addr), .req_func3(req_func3),
    .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_data(rd3), .rsp_err(re3),
    .clr_start(clr_start), .clr_busy(busy3), .clr_done(done3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitors for the two latencies.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rv1) begin
      if (q1.size() == 0) check_val("lat1_spurious", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check_val("lat1_cycle", 32'(cyc), 32'(e.c));
        check_val("lat1_data", rd1, e.d);
        check_val("lat1_err", 32'(re1), 32'(e.e));
      end
    end else if (q1.size() != 0 && q1[0].c < cyc) begin
      check_val("lat1_missing", 32'(cyc), 32'(q1[0].c));
      void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (rv3) begin
      if (q3.size() == 0) check_val("lat3_spurious", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        check_val("lat3_cycle", 32'(cyc), 32'(e.c));
        check_val("lat3_data", rd3, e.d);
        check_val("lat3_err", 32'(re3), 32'(e.e));
      end
    end else if (q3.size() != 0 && q3[0].c < cyc) begin
      check_val("lat3_missing", 32'(cyc), 32'(q3[0].c));
      void'(q3.pop_front());
    end
  end

  task automatic req(input logic we, input logic [5:0] addr, input logic [2:0] f3,
                     input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                     input logic clr = 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_func3 = f3;
    req_wdata = wd;
    clr_start = clr;
    check_val("req_ready", 32'(rdy1 & rdy3), 32'd1);
    q1.push_back('{d: ed, e: ee, c: cyc + 1});
    q3.push_back('{d: ed, e: ee, c: cyc + 3});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
      clr_start = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int b1, b3, nr1, nr3, d1, d3, n;
    repeat (3) @(negedge clk);
    check_val("rst_rsp_valid", 32'({rv1, rv3}), 32'd0);
    check_val("rst_rsp_data", rd1 | rd3, 32'd0);
    check_val("rst_rsp_err", 32'({re1, re3}), 32'd0);
    check_val("rst_clr_busy", 32'({busy1, busy3}), 32'd0);
    check_val("rst_clr_done", 32'({done1, done3}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_ready", 32'({rdy1, rdy3}), 32'd3);

    // Load extension at every width
    req(1'b1, 6'h10, 3'b010, 32'hFFFF_ABCD, 32'd0, 1'b0);
    req(1'b0, 6'h10, 3'b000, 32'd0, 32'hFFFF_FFCD, 1'b0);
    req(1'b0, 6'h10, 3'b001, 32'd0, 32'hFFFF_ABCD, 1'b0);
    req(1'b0, 6'h10, 3'b010, 32'd0, 32'hFFFF_ABCD, 1'b0);
    req(1'b0, 6'h10, 3'b100, 32'd0, 32'h0000_00CD, 1'b0);
    req(1'b0, 6'h10, 3'b101, 32'd0, 32'h0000_ABCD, 1'b0);
    req(1'b0, 6'h11, 3'b000, 32'd0, 32'hFFFF_FFAB, 1'b0);
    req(1'b0, 6'h13, 3'b100, 32'd0, 32'h0000_00FF, 1'b0);
    req(1'b0, 6'h12, 3'b001, 32'd0, 32'hFFFF_FFFF, 1'b0);
    idle(5);

    // Byte-lane masked stores
    req(1'b1, 6'h20, 3'b010, 32'h1122_3344, 32'd0, 1'b0);
    req(1'b1, 6'h22, 3'b000, 32'h0000_00AA, 32'd0, 1'b0);
    req(1'b1, 6'h20, 3'b001, 32'h0000_BEEF, 32'd0, 1'b0);
    req(1'b0, 6'h20, 3'b010, 32'd0, 32'h11AA_BEEF, 1'b0);

    // Misaligned and illegal accesses write nothing
    req(1'b0, 6'h21, 3'b001, 32'd0, 32'd0, 1'b1);
    req(1'b1, 6'h22, 3'b010, 32'hDEAD_BEEF, 32'd0, 1'b1);
    req(1'b0, 6'h20, 3'b011, 32'd0, 32'd0, 1'b1);
    req(1'b1, 6'h20, 3'b100, 32'h0000_0055, 32'd0, 1'b1);
    req(1'b1, 6'h23, 3'b001, 32'h0000_7777, 32'd0, 1'b1);
    req(1'b0, 6'h20, 3'b010, 32'd0, 32'h11AA_BEEF, 1'b0);

    // Read-after-write on consecutive cycles
    req(1'b1, 6'h30, 3'b010, 32'h5A5A_5A5A, 32'd0, 1'b0);
    req(1'b0, 6'h30, 3'b010, 32'd0, 32'h5A5A_5A5A, 1'b0);
    idle(5);

    // Full clear with a request in the clr_start cycle
    for (int i = 0; i < 16; i++)
      req(1'b1, 6'(i * 4), 3'b010, 32'hC0DE_0000 | 32'(i), 32'd0, 1'b0);
    req(1'b0, 6'h10, 3'b010, 32'd0, 32'hC0DE_0004, 1'b0, 1'b1);
    b1 = 0; b3 = 0; nr1 = 0; nr3 = 0; d1 = 0; d3 = 0;
    for (int k = 0; k < 40; k++) begin
      idle(1);
      if (busy1) b1++;
      if (busy3) b3++;
      if (!rdy1) nr1++;
      if (!rdy3) nr3++;
      if (busy1 == rdy1) nr1 += 100;
      if (busy3 == rdy3) nr3 += 100;
      if (done1) d1++;
      if (done3) d3++;
    end
    check_val("clr_busy_cycles_l1", 32'(b1), 32'd16);
    check_val("clr_busy_cycles_l3", 32'(b3), 32'd16);
    check_val("clr_notready_l1", 32'(nr1), 32'd16);
    check_val("clr_notready_l3", 32'(nr3), 32'd16);
    check_val("clr_done_pulses_l1", 32'(d1), 32'd1);
    check_val("clr_done_pulses_l3", 32'(d3), 32'd1);
    for (int i = 0; i < 16; i++)
      req(1'b0, 6'(i * 4), 3'b010, 32'd0, 32'd0, 1'b0);
    idle(5);

    // Reset in the fifth cycle of a clear
    for (int i = 0; i < 8; i++)
      req(1'b1, 6'(i * 4), 3'b010, 32'h0BAD_0000 | 32'(i), 32'd0, 1'b0);
    idle(4);
    @(negedge clk);
    clr_start = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && n < 5; k++) begin
      idle(1);
      if (busy1 && busy3) n++;
    end
    check_val("clr_reached_cycle5", 32'(n), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check_val("rstclr_busy", 32'({busy1, busy3}), 32'd0);
    check_val("rstclr_done", 32'({done1, done3}), 32'd0);
    check_val("rstclr_rsp_valid", 32'({rv1, rv3}), 32'd0);
    rst = 1'b0;
    d1 = 0;
    for (int k = 0; k < 20; k++) begin
      idle(1);
      if (done1 || done3) d1++;
    end
    check_val("rstclr_no_done", 32'(d1), 32'd0);
    for (int i = 0; i < 4; i++)
      req(1'b0, 6'(i * 4), 3'b010, 32'd0, 32'd0, 1'b0);
    req(1'b0, 6'h14, 3'b010, 32'd0, 32'h0BAD_0005, 1'b0);
    idle(6);

    check_val("drain_lat1", 32'(q1.size()), 32'd0);
    check_val("drain_lat3", 32'(q3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
